mole_hit_judge: RTL

- Consumer end of the mole-position interface: takes the mole index produced by the random mole generator and the player's five push-buttons.
- Decides hit, wrong-button miss or timeout miss for each mole; keeps score and miss count; asserts game-over.
- Drives the mole LED one-hot while the mole is up.
- Sits between the RNG block and the score/seven-segment display logic.

---
 rtl/mole_pkg.sv | 32 +++
 rtl/btn_sync_edge.sv | 84 ++++++++
 rtl/mole_hit_judge.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mole_pkg.sv
// -----------------------------------------------------------------------------
// mole_pkg
// Shared types and helpers for the whack-a-mole hit judge.
//   state_t   : judge FSM states (IDLE, UP, FLASH, OVER)
//   NUM_MOLES : number of mole positions / push-buttons
//   onehot5   : mole index 0..4 -> one-hot LED pattern, anything else -> 0
// -----------------------------------------------------------------------------
package mole_pkg;

    localparam int NUM_MOLES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        FLASH = 2'd2,
        OVER  = 2'd3
    } state_t;

    function automatic logic [NUM_MOLES-1:0] onehot5(input logic [2:0] idx);
        logic [NUM_MOLES-1:0] result;
        case (idx)
            3'd0:    result = 5'b00001;
            3'd1:    result = 5'b00010;
            3'd2:    result = 5'b00100;
            3'd3:    result = 5'b01000;
            3'd4:    result = 5'b10000;
            default: result = 5'b00000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Conditions asynchronous push-buttons: a 2-flop synchronizer per bit, an
// optional debounce stage, then a registered rising-edge detect.
// Without debounce a press event appears 3 clocks after the button edge.
//
// Configuration macro:
//   MOLE_DEBOUNCE_EN - when defined, each synchronized bit must hold a new
//                      level for 2^16 clocks before that level is accepted.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   WIDTH raw buttons, active-high, asynchronous to clk
//   pe     out  WIDTH one-cycle press events (rising edges)
// -----------------------------------------------------------------------------
module btn_sync_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] pe
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef MOLE_DEBOUNCE_EN
    localparam int DB_W = 16;

    logic [WIDTH-1:0][DB_W-1:0] db_cnt;
    logic [WIDTH-1:0]           stable;

    // The counter runs only while the synchronized level disagrees with the
    // accepted level; any bounce back to the accepted level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            stable <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == {DB_W{1'b1}}) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign level = stable;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= '0;
            pe      <= '0;
        end else begin
            level_d <= level;
            pe      <= level & ~level_d;
        end
    end

endmodule

// File: rtl/mole_hit_judge.sv
// -----------------------------------------------------------------------------
// mole_hit_judge
// Judges each mole from the RNG block against the player's buttons: hit,
// wrong-button miss, timeout miss or abandoned-mole miss. Keeps a saturating
// score and a miss count, and raises gameOver after MAX_MISSES misses.
//
// State table:
//   IDLE  | no mole up, waiting for a valid moleValid strobe
//   UP    | mole LED lit, window timer running, judging every cycle
//   FLASH | feedback pause after a hit or miss, all inputs ignored
//   OVER  | game finished, everything ignored until reset
//
// Configuration macro:
//   MOLE_DEBOUNCE_EN - enables button debounce inside btn_sync_edge
//                      (adds 2^16 clocks of press latency).
//
// Ports:
//   clkGlobal  in   system clock, rising edge
//   resetN     in   asynchronous active-low reset
//   moleIdx    in   mole position, 0..4 valid, 5..7 ignored
//   moleValid  in   one-cycle strobe qualifying moleIdx
//   btn        in   raw push-buttons, active-high, asynchronous
//   ledOut     out  one-hot mole LED, 0 when no mole is up
//   hitPulse   out  one-cycle pulse per hit
//   missPulse  out  one-cycle pulse per miss
//   score      out  saturating hit count
//   misses     out  miss count
//   gameOver   out  high once misses reaches MAX_MISSES
// -----------------------------------------------------------------------------
module mole_hit_judge
    import mole_pkg::*;
#(
    parameter int WINDOW_CYCLES = 50_000_000,
    parameter int FLASH_CYCLES  = 12_500_000,
    parameter int MAX_MISSES    = 5,
    parameter int SCORE_W       = 8
) (
    input  logic               clkGlobal,
    input  logic               resetN,
    input  logic [2:0]         moleIdx,
    input  logic               moleValid,
    input  logic [4:0]         btn,
    output logic [4:0]         ledOut,
    output logic               hitPulse,
    output logic               missPulse,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         misses,
    output logic               gameOver
);

    localparam int TIMER_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES - 1);
    localparam logic [2:0]         MISS_LIMIT = 3'(MAX_MISSES);

    logic [NUM_MOLES-1:0] pe;
    logic [NUM_MOLES-1:0] mole_mask;
    logic [NUM_MOLES-1:0] new_mask;
    logic                 strobe_ok;
    logic [TIMER_W-1:0]   timer;
    logic [FLASH_W-1:0]   flash_cnt;
    state_t               state;

    btn_sync_edge #(
        .WIDTH (NUM_MOLES)
    ) u_btn_sync_edge (
        .clk   (clkGlobal),
        .rst_n (resetN),
        .raw   (btn),
        .pe    (pe)
    );

    // Out-of-range indices map to an all-zero mask, so they never count as a
    // mole: not in IDLE and not as an abandoning strobe in UP.
    assign new_mask  = onehot5(moleIdx);
    assign strobe_ok = moleValid && (new_mask != '0);

    always_ff @(posedge clkGlobal or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            timer     <= '0;
            flash_cnt <= '0;
            mole_mask <= '0;
            ledOut    <= '0;
            hitPulse  <= 1'b0;
            missPulse <= 1'b0;
            score     <= '0;
            misses    <= '0;
            gameOver  <= 1'b0;
        end else begin
            hitPulse  <= 1'b0;
            missPulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (strobe_ok) begin
                        mole_mask <= new_mask;
                        ledOut    <= new_mask;
                        timer     <= TIMER_LOAD;
                        state     <= UP;
                    end
                end

                UP: begin
                    // mole_mask is always exactly one bit here, so equality
                    // also rejects presses that add extra buttons.
                    if (pe == mole_mask) begin
                        hitPulse  <= 1'b1;
                        if (score != {SCORE_W{1'b1}}) begin
                            score <= score + 1'b1;
                        end
                        ledOut    <= '0;
                        flash_cnt <= FLASH_LOAD;
                        state     <= FLASH;
                    end else if ((pe != '0) || (timer == '0) || strobe_ok) begin
                        missPulse <= 1'b1;
                        if (misses != 3'd7) begin
                            misses <= misses + 3'd1;
                        end
                        ledOut    <= '0;
                        flash_cnt <= FLASH_LOAD;
                        state     <= FLASH;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                FLASH: begin
                    if (flash_cnt == '0) begin
                        if (misses >= MISS_LIMIT) begin
                            gameOver <= 1'b1;
                            state    <= OVER;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        flash_cnt <= flash_cnt - 1'b1;
                    end
                end

                OVER: begin
                    ledOut   <= '0;
                    gameOver <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
